multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: OPCODE_W, default 6, width of instruction opcode field.
REQ-002 Parameter: STATE_W, default 4, width of state register and debug state output.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset; sampled on rising edge of clock only.
REQ-005 Port: opcode  input  OPCODE_W  instruction[31:26] from instruction register.
REQ-006 Port: mem_ready  input  1  memory handshake; high = current access completes this cycle.
REQ-007 Ports, outputs, 1 bit each: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-008 Ports, outputs, 2 bits each: alu_src_b, alu_op, pc_source.
REQ-009 Port: state  output  STATE_W  current FSM state, debug only.
REQ-010 reg_dst SHALL drive the RegDst select of the register-file write-address mux: 1 = rd, 0 = rt.

Function
REQ-011 State encodings SHALL be: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-012 Outputs SHALL be Moore-decoded from state, except pc_write and ir_write in FETCH, which are qualified by mem_ready.
REQ-013 Any output not listed for a state in REQ-014 to REQ-025 SHALL be 0.
REQ-014 FETCH: mem_read=1, alu_src_b=01; ir_write=pc_write=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-015 DECODE: alu_src_b=11. Next state by opcode: 0x00 -> EXECUTE; 0x23 or 0x2B -> MEMADDR; 0x04 -> BRANCH; 0x02 -> JUMP; any other opcode -> FETCH.
REQ-016 MEMADDR: alu_src_a=1, alu_src_b=10. Next state: MEMREAD for 0x23, MEMWRITE for 0x2B.
REQ-017 MEMREAD: mem_read=1, i_or_d=1; stay while mem_ready=0, else go to MEMWB.
REQ-018 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-019 MEMWRITE: mem_write=1, i_or_d=1; stay while mem_ready=0, else go to FETCH.
REQ-020 EXECUTE: alu_src_a=1, alu_op=10; next state ALUWB.
REQ-021 ALUWB: reg_write=1, reg_dst=1; next state FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01; next state FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10; next state FETCH.
REQ-024 Unused encodings 12-15 SHALL output all zeros and go to FETCH.
REQ-025 opcode SHALL be sampled only in DECODE and MEMADDR; changes in other states SHALL have no effect.
REQ-026 Latencies: lw=5 cycles, sw=4 cycles, R-type=4 cycles, beq=3 cycles, j=3 cycles. Each wait cycle (mem_ready=0) adds one cycle.

Reset
REQ-027 While reset=1 at a rising edge, state SHALL load FETCH, regardless of current state or mem_ready.
REQ-028 While reset=1, pc_write, ir_write, reg_write, mem_write, mem_read and pc_write_cond SHALL be forced to 0.
REQ-029 Reset asserted mid-instruction SHALL abandon the instruction with no further write strobes.
REQ-030 The first cycle after reset deasserts SHALL be a FETCH cycle.

Configuration
REQ-031 Macro ADDI_SUPPORT_EN defined: DECODE with opcode 0x08 SHALL go to ADDIEX.
REQ-032 ADDIEX (alu_src_a=1, alu_src_b=10) SHALL be followed by ADDIWB (reg_write=1, reg_dst=0, mem_to_reg=0), then FETCH.
REQ-033 Macro undefined: opcode 0x08 SHALL be treated as unknown (DECODE -> FETCH); states 10 and 11 SHALL behave as in REQ-024.

Structure
REQ-034 State encodings, opcode constants (0x00, 0x02, 0x04, 0x08, 0x23, 0x2B) and alu_op codes SHALL live in shared include mips_defs.vh.
REQ-035 Next-state dispatch from DECODE SHALL be a sub-module, opcode_dispatch, combinational, opcode in and target state out.

Verification
REQ-036 reset, then opcode=0x23, mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1, reg_dst=0, mem_to_reg=1 only in state 4.
REQ-037 opcode=0x00 -> states 0,1,6,7,0; reg_dst=1, reg_write=1 in state 7; alu_op=10 in state 6.
REQ-038 opcode=0x04, then 0x02 -> BRANCH gives pc_write_cond=1, pc_source=01; JUMP gives pc_write=1, pc_source=10; 3 cycles each.
REQ-039 mem_ready=0 for 2 cycles in FETCH and in MEMWRITE (opcode=0x2B) -> state holds, ir_write=pc_write=0 while waiting; sw totals 8 cycles.
REQ-040 opcode=0x3F -> DECODE returns to FETCH with no write strobes; opcode=0x08 -> ADDIWB writes with macro defined, returns to FETCH without.
REQ-041 reset=1 in MEMREAD -> next state 0, no reg_write pulse, strobes 0 during reset.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state encodings, opcode constants and alu_op codes for the multicycle MIPS control FSM
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDIEX   = 4'd10,
    ADDIWB   = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
endpackage

// File: rtl/multicycle_control_opcode_dispatch.sv
// opcode_dispatch: combinational DECODE next-state lookup; ADDI_SUPPORT_EN enables the addi path
module opcode_dispatch
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output state_t              target
);
  always_comb begin
    target = FETCH;
    if (opcode == OPCODE_W'(OP_RTYPE)) target = EXECUTE;
    if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) target = MEMADDR;
    if (opcode == OPCODE_W'(OP_BEQ)) target = BRANCH;
    if (opcode == OPCODE_W'(OP_J)) target = JUMP;
`ifdef ADDI_SUPPORT_EN
    if (opcode == OPCODE_W'(OP_ADDI)) target = ADDIEX;
`endif
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with Moore-decoded datapath controls
// ADDI_SUPPORT_EN adds the ADDIEX/ADDIWB path for opcode 0x08.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [STATE_W-1:0]  state
);
  state_t st, disp;
  logic ex, wb;
  opcode_dispatch #(.OPCODE_W(OPCODE_W)) u_dispatch (.opcode(opcode), .target(disp));
  always_ff @(posedge clock) begin
    if (reset) st <= FETCH;
    else begin
      case (st)
        FETCH:    st <= mem_ready ? DECODE : FETCH;
        DECODE:   st <= disp;
        MEMADDR:  st <= opcode == OPCODE_W'(OP_LW) ? MEMREAD : opcode == OPCODE_W'(OP_SW) ? MEMWRITE : FETCH;
        MEMREAD:  st <= mem_ready ? MEMWB : MEMREAD;
        MEMWRITE: st <= mem_ready ? FETCH : MEMWRITE;
        EXECUTE:  st <= ALUWB;
`ifdef ADDI_SUPPORT_EN
        ADDIEX:   st <= ADDIWB;
`endif
        default:  st <= FETCH;
      endcase
    end
  end
  // write strobes are gated by reset so an abandoned instruction cannot write
  always_comb begin
    ex = 1'b0;
    wb = 1'b0;
`ifdef ADDI_SUPPORT_EN
    ex = st == ADDIEX;
    wb = st == ADDIWB;
`endif
    pc_write      = !reset && ((st == FETCH && mem_ready) || st == JUMP);
    ir_write      = !reset && st == FETCH && mem_ready;
    mem_read      = !reset && (st == FETCH || st == MEMREAD);
    mem_write     = !reset && st == MEMWRITE;
    reg_write     = !reset && (st == MEMWB || st == ALUWB || wb);
    pc_write_cond = !reset && st == BRANCH;
    i_or_d        = st == MEMREAD || st == MEMWRITE;
    mem_to_reg    = st == MEMWB;
    reg_dst       = st == ALUWB;
    alu_src_a     = st == MEMADDR || st == EXECUTE || st == BRANCH || ex;
    alu_src_b     = st == FETCH ? 2'b01 : st == DECODE ? 2'b11 : (st == MEMADDR || ex) ? 2'b10 : 2'b00;
    alu_op        = st == EXECUTE ? ALU_FUNCT : st == BRANCH ? ALU_SUB : ALU_ADD;
    pc_source     = st == BRANCH ? 2'b01 : st == JUMP ? 2'b10 : 2'b00;
    state         = STATE_W'(st);
  end
endmodule
